// File: rtl/bp_me_pkg.sv
// Shared types for the LCE-id to coherence-NoC coordinate lookup table:
// table entry layout, init FSM states and the reset-time default mapping.
package bp_me_pkg;

    localparam int lut_x_cord_width_gp = 4;
    localparam int lut_y_cord_width_gp = 4;
    localparam int lut_cid_width_gp    = 2;

    typedef struct packed {
        logic                           v;
        logic [lut_cid_width_gp-1:0]    cid;
        logic [lut_y_cord_width_gp-1:0] y;
        logic [lut_x_cord_width_gp-1:0] x;
    } bp_lce_cord_entry_s;

    typedef enum logic [1:0] {
        e_reset = 2'd0,
        e_init  = 2'd1,
        e_ready = 2'd2
    } bp_lce_cord_lut_state_e;

    // Two LCEs (I$ and D$) share each core tile, so the tile index is i>>1.
    function automatic int default_x(input int i, input int cc_x_dim, input int sac_x_dim);
        return sac_x_dim + ((i >> 1) % cc_x_dim);
    endfunction

    function automatic int default_y(input int i, input int cc_x_dim, input int ic_y_dim);
        return ic_y_dim + ((i >> 1) / cc_x_dim);
    endfunction

    function automatic bp_lce_cord_entry_s default_entry(input int i, input int num_default,
                                                         input int cc_x_dim, input int sac_x_dim,
                                                         input int ic_y_dim);
        bp_lce_cord_entry_s e;
        int xv;
        int yv;
        e  = '0;
        xv = default_x(i, cc_x_dim, sac_x_dim);
        yv = default_y(i, cc_x_dim, ic_y_dim);
        if (i < num_default) begin
            e.v   = 1'b1;
            e.x   = xv[lut_x_cord_width_gp-1:0];
            e.y   = yv[lut_y_cord_width_gp-1:0];
            e.cid = lut_cid_width_gp'(i & 1);
        end
        return e;
    endfunction

endpackage

// File: rtl/bp_me_lce_id_to_cord_lut_if.sv
// Config-write and lookup signals of the LCE-id to coordinate table.
// Handshakes: a config write or lookup request transfers on a cycle where its valid and
// ready are both high; a lookup result is offered with lookup_v_o and consumed with yumi.
interface bp_me_lce_id_to_cord_lut_if
    import bp_me_pkg::*;
#(
    parameter int lce_id_width_p = 3,
    parameter int x_cord_width_p = 4,
    parameter int y_cord_width_p = 4,
    parameter int cid_width_p    = 2,
    parameter int num_lookup_p   = 2
);
    logic                                                  init_done_o;
    logic                                                  cfg_w_v_i;
    logic                                                  cfg_ready_o;
    logic [lce_id_width_p-1:0]                             cfg_addr_i;
    logic                                                  cfg_entry_v_i;
    logic [x_cord_width_p+y_cord_width_p-1:0]              cfg_cord_i;
    logic [cid_width_p-1:0]                                cfg_cid_i;
    logic [num_lookup_p-1:0]                               lookup_v_i;
    logic [num_lookup_p*lce_id_width_p-1:0]                lookup_id_i;
    logic [num_lookup_p-1:0]                               lookup_ready_o;
    logic [num_lookup_p-1:0]                               lookup_v_o;
    logic [num_lookup_p*(x_cord_width_p+y_cord_width_p)-1:0] lookup_cord_o;
    logic [num_lookup_p*cid_width_p-1:0]                   lookup_cid_o;
    logic [num_lookup_p-1:0]                               lookup_miss_o;
    logic [num_lookup_p-1:0]                               lookup_yumi_i;
    bp_lce_cord_lut_state_e                                state_o;

    modport master (
        output cfg_w_v_i, cfg_addr_i, cfg_entry_v_i, cfg_cord_i, cfg_cid_i,
        output lookup_v_i, lookup_id_i, lookup_yumi_i,
        input  init_done_o, cfg_ready_o, lookup_ready_o, lookup_v_o,
        input  lookup_cord_o, lookup_cid_o, lookup_miss_o, state_o
    );

    modport slave (
        input  cfg_w_v_i, cfg_addr_i, cfg_entry_v_i, cfg_cord_i, cfg_cid_i,
        input  lookup_v_i, lookup_id_i, lookup_yumi_i,
        output init_done_o, cfg_ready_o, lookup_ready_o, lookup_v_o,
        output lookup_cord_o, lookup_cid_o, lookup_miss_o, state_o
    );

endinterface

// File: rtl/bp_me_lce_id_to_cord_lut_port.sv
// One lookup channel: a single-entry result register with valid/yumi handshake.
// The table read is already zeroed for out-of-range ids, so entry_i.v alone decides hit/miss.
module bp_me_lce_id_to_cord_lut_port
    import bp_me_pkg::*;
(
    input  logic                                               clk_i,
    input  logic                                               reset_i,
    input  logic                                               init_done_i,
    input  logic                                               v_i,
    input  bp_lce_cord_entry_s                                 entry_i,
    input  logic                                               yumi_i,
    output logic                                               ready_o,
    output logic                                               v_o,
    output logic [lut_x_cord_width_gp+lut_y_cord_width_gp-1:0] cord_o,
    output logic [lut_cid_width_gp-1:0]                        cid_o,
    output logic                                               miss_o
);

    logic                                               v_q, v_d;
    logic                                               miss_q, miss_d;
    logic [lut_x_cord_width_gp+lut_y_cord_width_gp-1:0] cord_q, cord_d;
    logic [lut_cid_width_gp-1:0]                        cid_q, cid_d;
    logic                                               accept;

    assign ready_o = init_done_i & (~v_q | yumi_i);
    assign accept  = v_i & ready_o;

    always_comb begin
        v_d    = v_q;
        miss_d = miss_q;
        cord_d = cord_q;
        cid_d  = cid_q;
        if (accept) begin
            v_d    = 1'b1;
            miss_d = ~entry_i.v;
            cord_d = entry_i.v ? {entry_i.y, entry_i.x} : '0;
            cid_d  = entry_i.v ? entry_i.cid : '0;
        end else if (yumi_i) begin
            v_d    = 1'b0;
            miss_d = 1'b0;
            cord_d = '0;
            cid_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v_q    <= 1'b0;
            miss_q <= 1'b0;
            cord_q <= '0;
            cid_q  <= '0;
        end else begin
            v_q    <= v_d;
            miss_q <= miss_d;
            cord_q <= cord_d;
            cid_q  <= cid_d;
        end
    end

    assign v_o    = v_q;
    assign cord_o = cord_q;
    assign cid_o  = cid_q;
    assign miss_o = miss_q;

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_q));

endmodule

// File: rtl/bp_me_lce_id_to_cord_lut.sv
// Programmable LCE-id to coherence-NoC coordinate table. After reset it fills itself with the
// default core-complex mapping (one entry per cycle), then serves config writes and lookups.
module bp_me_lce_id_to_cord_lut
    import bp_me_pkg::*;
#(
    parameter int num_lce_p      = 8,
    parameter int lce_id_width_p = 3,
    parameter int x_cord_width_p = 4,
    parameter int y_cord_width_p = 4,
    parameter int cid_width_p    = 2,
    parameter int num_lookup_p   = 2,
    parameter int num_default_p  = 4,
    parameter int cc_x_dim_p     = 2,
    parameter int sac_x_dim_p    = 1,
    parameter int ic_y_dim_p     = 1
)
(
    input  logic                          clk_i,
    input  logic                          reset_i,
    bp_me_lce_id_to_cord_lut_if.slave     lut_if
);

    localparam int cord_width_lp = x_cord_width_p + y_cord_width_p;
    localparam logic [lce_id_width_p:0]   num_lce_lp = (lce_id_width_p+1)'(num_lce_p);
    localparam logic [lce_id_width_p-1:0] last_id_lp = lce_id_width_p'(num_lce_p - 1);

    if ((1 << lce_id_width_p) < num_lce_p || num_default_p > num_lce_p) begin : g_size_chk
        $error("lce id width or default entry count inconsistent with num_lce_p");
    end
    if (x_cord_width_p != lut_x_cord_width_gp || y_cord_width_p != lut_y_cord_width_gp
        || cid_width_p != lut_cid_width_gp) begin : g_width_chk
        $error("field widths differ from the shared entry layout");
    end
    for (genvar i = 0; i < num_default_p; i++) begin : g_default_chk
        if (default_x(i, cc_x_dim_p, sac_x_dim_p) >= (1 << x_cord_width_p)
            || default_y(i, cc_x_dim_p, ic_y_dim_p) >= (1 << y_cord_width_p)) begin : g_err
            $error("default coordinate does not fit its field");
        end
    end

    bp_lce_cord_lut_state_e    state_q, state_d;
    logic [lce_id_width_p-1:0] init_cnt_q, init_cnt_d;
    bp_lce_cord_entry_s        table_q [num_lce_p];
    bp_lce_cord_entry_s        table_d [num_lce_p];
    logic                      init_done;
    logic                      init_we;
    logic                      cfg_we;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= e_reset;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        unique case (state_q)
            e_reset: begin
                state_d    = e_init;
                init_cnt_d = '0;
            end
            e_init: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == last_id_lp) begin
                    state_d    = e_ready;
                    init_cnt_d = '0;
                end
            end
            e_ready: state_d = e_ready;
            default: state_d = e_reset;
        endcase
    end

    always_comb begin
        init_done = (state_q == e_ready);
        init_we   = (state_q == e_init);
    end

    assign cfg_we = init_done & lut_if.cfg_w_v_i & ({1'b0, lut_if.cfg_addr_i} < num_lce_lp);

    // Lookups read table_q, so a same-cycle write to the looked-up id is seen only afterwards.
    always_comb begin
        table_d = table_q;
        if (init_we) begin
            table_d[init_cnt_q] = default_entry(int'(init_cnt_q), num_default_p,
                                                cc_x_dim_p, sac_x_dim_p, ic_y_dim_p);
        end else if (cfg_we) begin
            table_d[lut_if.cfg_addr_i].v   = lut_if.cfg_entry_v_i;
            table_d[lut_if.cfg_addr_i].cid = lut_if.cfg_cid_i;
            table_d[lut_if.cfg_addr_i].y   = lut_if.cfg_cord_i[cord_width_lp-1:x_cord_width_p];
            table_d[lut_if.cfg_addr_i].x   = lut_if.cfg_cord_i[x_cord_width_p-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < num_lce_p; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            table_q <= table_d;
        end
    end

    logic [num_lookup_p-1:0]               lookup_ready;
    logic [num_lookup_p-1:0]               lookup_v;
    logic [num_lookup_p-1:0]               lookup_miss;
    logic [num_lookup_p*cord_width_lp-1:0] lookup_cord;
    logic [num_lookup_p*cid_width_p-1:0]   lookup_cid;

    for (genvar c = 0; c < num_lookup_p; c++) begin : g_port
        logic [lce_id_width_p-1:0] id;
        logic                      in_range;
        bp_lce_cord_entry_s        rd_entry;

        assign id       = lut_if.lookup_id_i[c*lce_id_width_p +: lce_id_width_p];
        assign in_range = ({1'b0, id} < num_lce_lp);
        assign rd_entry = in_range ? table_q[id] : '0;

        bp_me_lce_id_to_cord_lut_port u_port (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .init_done_i (init_done),
            .v_i         (lut_if.lookup_v_i[c]),
            .entry_i     (rd_entry),
            .yumi_i      (lut_if.lookup_yumi_i[c]),
            .ready_o     (lookup_ready[c]),
            .v_o         (lookup_v[c]),
            .cord_o      (lookup_cord[c*cord_width_lp +: cord_width_lp]),
            .cid_o       (lookup_cid[c*cid_width_p +: cid_width_p]),
            .miss_o      (lookup_miss[c])
        );
    end

    assign lut_if.init_done_o    = init_done;
    assign lut_if.cfg_ready_o    = init_done;
    assign lut_if.lookup_ready_o = lookup_ready;
    assign lut_if.lookup_v_o     = lookup_v;
    assign lut_if.lookup_cord_o  = lookup_cord;
    assign lut_if.lookup_cid_o   = lookup_cid;
    assign lut_if.lookup_miss_o  = lookup_miss;
    assign lut_if.state_o        = state_q;

endmodule

// File: tb/tb_bp_me_lce_id_to_cord_lut.sv
// Bench for the LCE-id to coordinate table: reset/init timing, directed and random lookups
// checked against an independent table model through per-channel expected-result queues.
module tb_bp_me_lce_id_to_cord_lut;
    import bp_me_pkg::*;

    localparam int NL  = 8;
    localparam int IW  = 3;
    localparam int XW  = 4;
    localparam int YW  = 4;
    localparam int CW  = 2;
    localparam int NC  = 2;
    localparam int CDW = XW + YW;
    localparam int RW  = 1 + CDW + CW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bp_me_lce_id_to_cord_lut_if #(.lce_id_width_p(IW), .x_cord_width_p(XW), .y_cord_width_p(YW),
                                  .cid_width_p(CW), .num_lookup_p(NC)) lut_if ();

    bp_me_lce_id_to_cord_lut #(
        .num_lce_p(NL), .lce_id_width_p(IW), .x_cord_width_p(XW), .y_cord_width_p(YW),
        .cid_width_p(CW), .num_lookup_p(NC), .num_default_p(4), .cc_x_dim_p(2),
        .sac_x_dim_p(1), .ic_y_dim_p(1)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .lut_if  (lut_if)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference table; defaults written out by hand from the core-complex geometry.
    logic          m_v    [NL];
    logic [CDW-1:0] m_cord [NL];
    logic [CW-1:0] m_cid  [NL];

    task automatic model_reset();
        logic [CDW-1:0] dc [4];
        dc[0] = 8'h11; dc[1] = 8'h11; dc[2] = 8'h12; dc[3] = 8'h12;
        for (int i = 0; i < NL; i++) begin
            m_v[i]    = (i < 4);
            m_cord[i] = (i < 4) ? dc[i] : '0;
            m_cid[i]  = (i < 4) ? CW'(i % 2) : '0;
        end
    endtask

    function automatic logic [RW-1:0] exp_of(input logic [IW-1:0] id);
        if (!m_v[id]) return {1'b1, {CDW{1'b0}}, {CW{1'b0}}};
        return {1'b0, m_cord[id], m_cid[id]};
    endfunction

    logic [RW-1:0] exp_q0[$];
    logic [RW-1:0] exp_q1[$];
    logic [NC-1:0] pend;
    logic [NC-1:0] auto_yumi;
    logic [NC-1:0] force_yumi;

    task automatic q_push(input int c, input logic [RW-1:0] v);
        if (c == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
    endtask

    task automatic mon_chan(input int c);
        logic [RW-1:0] got;
        logic [RW-1:0] front;
        int            sz;
        logic [IW-1:0] id;
        got = {lut_if.lookup_miss_o[c], lut_if.lookup_cord_o[c*CDW +: CDW],
               lut_if.lookup_cid_o[c*CW +: CW]};
        sz  = (c == 0) ? exp_q0.size() : exp_q1.size();
        if (pend[c]) chk($sformatf("latency_ch%0d", c), 32'(lut_if.lookup_v_o[c]), 32'd1);
        if (lut_if.lookup_v_o[c]) begin
            if (sz == 0) begin
                chk($sformatf("unexpected_ch%0d", c), 32'd1, 32'd0);
            end else begin
                front = (c == 0) ? exp_q0[0] : exp_q1[0];
                chk($sformatf("result_ch%0d", c), 32'(got), 32'(front));
                if (lut_if.lookup_yumi_i[c]) begin
                    if (c == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
                end
            end
        end
        pend[c] = lut_if.lookup_v_i[c] & lut_if.lookup_ready_o[c];
        if (pend[c]) begin
            id = lut_if.lookup_id_i[c*IW +: IW];
            q_push(c, exp_of(id));
        end
    endtask

    // Scoreboard: compare held/consumed results, queue expectations for accepted requests,
    // then apply the accepted config write (reads above see the pre-write table).
    always @(negedge clk) begin
        if (rst) begin
            exp_q0.delete();
            exp_q1.delete();
            pend = '0;
            model_reset();
        end else begin
            for (int c = 0; c < NC; c++) mon_chan(c);
            if (lut_if.cfg_w_v_i && lut_if.cfg_ready_o) begin
                m_v[lut_if.cfg_addr_i]    = lut_if.cfg_entry_v_i;
                m_cord[lut_if.cfg_addr_i] = lut_if.cfg_cord_i;
                m_cid[lut_if.cfg_addr_i]  = lut_if.cfg_cid_i;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        lut_if.lookup_yumi_i = rst ? '0 : ((auto_yumi | force_yumi) & lut_if.lookup_v_o);
    end

    task automatic clear_inputs();
        lut_if.lookup_v_i    = '0;
        lut_if.lookup_id_i   = '0;
        lut_if.cfg_w_v_i     = 1'b0;
        lut_if.cfg_addr_i    = '0;
        lut_if.cfg_entry_v_i = 1'b0;
        lut_if.cfg_cord_i    = '0;
        lut_if.cfg_cid_i     = '0;
    endtask

    // One cycle of stimulus, called and returning at posedge+1.
    task automatic step(input logic v0, input logic [IW-1:0] id0, input logic v1,
                        input logic [IW-1:0] id1, input logic wv, input logic [IW-1:0] wa,
                        input logic ev, input logic [CDW-1:0] wc, input logic [CW-1:0] wcid);
        lut_if.lookup_v_i    = {v1, v0};
        lut_if.lookup_id_i   = {id1, id0};
        lut_if.cfg_w_v_i     = wv;
        lut_if.cfg_addr_i    = wa;
        lut_if.cfg_entry_v_i = ev;
        lut_if.cfg_cord_i    = wc;
        lut_if.cfg_cid_i     = wcid;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_init(input string tag);
        int cyc;
        cyc = 0;
        while (cyc < 30) begin
            @(negedge clk);
            if (lut_if.init_done_o) break;
            chk({tag, "_cfg_ready_pre"}, 32'(lut_if.cfg_ready_o), 32'd0);
            chk({tag, "_lookup_ready_pre"}, 32'(lut_if.lookup_ready_o), 32'd0);
            @(posedge clk);
            cyc++;
        end
        // one edge leaves e_reset, then eight init writes
        chk({tag, "_init_cycles"}, 32'(cyc), 32'd9);
        chk({tag, "_state_ready"}, 32'(lut_if.state_o), 32'(e_ready));
        @(posedge clk); #1;
    endtask

    initial begin
        rst        = 1'b1;
        auto_yumi  = '0;
        force_yumi = '0;
        pend       = '0;
        clear_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_init_done", 32'(lut_if.init_done_o), 32'd0);
        chk("rst_cfg_ready", 32'(lut_if.cfg_ready_o), 32'd0);
        chk("rst_lookup_ready", 32'(lut_if.lookup_ready_o), 32'd0);
        chk("rst_lookup_v", 32'(lut_if.lookup_v_o), 32'd0);
        chk("rst_lookup_miss", 32'(lut_if.lookup_miss_o), 32'd0);
        chk("rst_state", 32'(lut_if.state_o), 32'(e_reset));
        @(posedge clk); #1;
        rst = 1'b0;
        wait_init("init");

        auto_yumi = '1;
        // default entries: id3 -> {1,2} cid1, id0 -> {1,1} cid0
        step(1, 3'd3, 1, 3'd0, 0, 0, 0, 0, 0);
        idle(1);
        // id5 misses by default, then gets programmed
        step(1, 3'd5, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 3'd5, 1, 8'h23, 2'd2);
        step(0, 0, 1, 3'd5, 0, 0, 0, 0, 0);
        idle(1);
        // same-cycle write and lookup of id2 returns the old entry
        step(1, 3'd2, 0, 0, 1, 3'd2, 1, 8'h44, 2'd0);
        step(1, 3'd2, 1, 3'd2, 0, 0, 0, 0, 0);
        idle(2);

        // hold a result for three cycles, then yumi with a back-to-back request
        auto_yumi = '0;
        step(1, 3'd3, 1, 3'd5, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_ready_ch0", 32'(lut_if.lookup_ready_o[0]), 32'd0);
            chk("hold_ready_ch1", 32'(lut_if.lookup_ready_o[1]), 32'd0);
            @(posedge clk); #1;
        end
        force_yumi = 2'b01;
        lut_if.lookup_v_i  = 2'b01;
        lut_if.lookup_id_i = {3'd0, 3'd1};
        @(negedge clk);
        chk("yumi_ready_ch0", 32'(lut_if.lookup_ready_o[0]), 32'd1);
        @(posedge clk); #1;
        clear_inputs();
        force_yumi = '0;
        idle(1);
        auto_yumi = '1;
        idle(2);

        // random traffic with random consumption
        for (int k = 0; k < 40; k++) begin
            auto_yumi = NC'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), IW'($urandom_range(0, NL-1)),
                 1'($urandom_range(0, 1)), IW'($urandom_range(0, NL-1)),
                 1'($urandom_range(0, 1)), IW'($urandom_range(0, NL-1)),
                 1'($urandom_range(0, 1)), CDW'($urandom_range(0, 255)), CW'($urandom_range(0, 3)));
        end
        auto_yumi = '1;
        idle(3);

        // reprogram id5, leave results pending, then reset in the middle of the stream
        step(0, 0, 0, 0, 1, 3'd5, 1, 8'h23, 2'd2);
        auto_yumi = '0;
        step(1, 3'd5, 1, 3'd2, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_lookup_v", 32'(lut_if.lookup_v_o), 32'd0);
        chk("midrst_lookup_miss", 32'(lut_if.lookup_miss_o), 32'd0);
        chk("midrst_lookup_ready", 32'(lut_if.lookup_ready_o), 32'd0);
        chk("midrst_init_done", 32'(lut_if.init_done_o), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        wait_init("reinit");
        auto_yumi = '1;
        step(1, 3'd5, 1, 3'd2, 0, 0, 0, 0, 0);
        idle(3);

        chk("drain_ch0", 32'(exp_q0.size()), 32'd0);
        chk("drain_ch1", 32'(exp_q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "bench did not finish");
    end

endmodule
